// File: rtl/ffo_pos_decoder.sv
// ffo_pos_decoder: rebuilds a bit mask from a stream of (valid, position) beats.
// Each accepted beat with in_v=1 sets bit in_p of an ascending-index accumulator
// (index 0 = leftmost bit). On the frame's last beat the rebuilt word is
// presented together with its population count and duplicate/error flags.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready     input beat handshake
//   in_v, in_p, in_last   beat payload: position valid, position (in_p[0] = MSB), frame end
//   out_valid/out_ready   output word handshake
//   out_b                 rebuilt vector, out_b[k] = 1 if position k was seen
//   out_cnt               number of distinct positions set in out_b
//   out_dup               a valid beat repeated an already-set position
//   out_err               a valid beat carried a position >= W (beat ignored)
module ffo_pos_decoder #(
    parameter int unsigned W  = 32,
    parameter int unsigned PW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_v,
    input  logic [0:PW-1] in_p,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [0:W-1]  out_b,
    output logic [0:PW]   out_cnt,
    output logic          out_dup,
    output logic          out_err
);

    localparam logic [0:0] ACCUM = 1'b0;
    localparam logic [0:0] HOLD  = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [0:W-1]  acc_q, acc_d;
    logic [0:PW]   cnt_q, cnt_d;
    logic          dup_q, dup_d;
    logic          err_q, err_d;
    logic [0:W-1]  ob_d;
    logic [0:PW]   ocnt_d;
    logic          odup_d, oerr_d;

    logic          accept;
    logic          in_range;
    logic          hit;
    logic          seen;
    logic          set_new;
    logic [0:W-1]  onehot;
    logic [0:W-1]  acc_upd;
    logic [0:PW]   cnt_upd;
    logic          dup_upd;
    logic          err_upd;

    // In HOLD the input side only moves when the held word is leaving.
    assign in_ready = (state_q == ACCUM) || out_ready;
    assign accept   = in_valid && in_ready;

    // Decode the position and fold the beat into the accumulator state.
    always_comb begin
        for (int k = 0; k < int'(W); k++) begin
            onehot[k] = (in_p == PW'(k));
        end
        in_range = ({1'b0, in_p} < (PW + 1)'(W));
        hit      = in_v && in_range;
        seen     = |(acc_q & onehot);
        set_new  = hit && !seen;
        acc_upd  = set_new ? (acc_q | onehot) : acc_q;
        cnt_upd  = cnt_q + (PW + 1)'(set_new);
        dup_upd  = dup_q || (hit && seen);
        err_upd  = err_q || (in_v && !in_range);
    end

    // Next-state and next-register values. The accumulator is always cleared
    // on entry to HOLD, so a beat accepted in HOLD starts from an empty frame.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        dup_d   = dup_q;
        err_d   = err_q;
        ob_d    = out_b;
        ocnt_d  = out_cnt;
        odup_d  = out_dup;
        oerr_d  = out_err;

        case (state_q)
            ACCUM: begin
                if (accept) begin
                    if (in_last) begin
                        ob_d    = acc_upd;
                        ocnt_d  = cnt_upd;
                        odup_d  = dup_upd;
                        oerr_d  = err_upd;
                        acc_d   = '0;
                        cnt_d   = '0;
                        dup_d   = 1'b0;
                        err_d   = 1'b0;
                        state_d = HOLD;
                    end else begin
                        acc_d = acc_upd;
                        cnt_d = cnt_upd;
                        dup_d = dup_upd;
                        err_d = err_upd;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    if (accept && in_last) begin
                        // Single-beat frame replaces the departing word.
                        ob_d    = acc_upd;
                        ocnt_d  = cnt_upd;
                        odup_d  = dup_upd;
                        oerr_d  = err_upd;
                        state_d = HOLD;
                    end else if (accept) begin
                        acc_d   = acc_upd;
                        cnt_d   = cnt_upd;
                        dup_d   = dup_upd;
                        err_d   = err_upd;
                        state_d = ACCUM;
                    end else begin
                        state_d = ACCUM;
                    end
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ACCUM;
            acc_q     <= '0;
            cnt_q     <= '0;
            dup_q     <= 1'b0;
            err_q     <= 1'b0;
            out_valid <= 1'b0;
            out_b     <= '0;
            out_cnt   <= '0;
            out_dup   <= 1'b0;
            out_err   <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            dup_q     <= dup_d;
            err_q     <= err_d;
            out_valid <= (state_d == HOLD);
            out_b     <= ob_d;
            out_cnt   <= ocnt_d;
            out_dup   <= odup_d;
            out_err   <= oerr_d;
        end
    end

endmodule

// File: tb/tb_ffo_pos_decoder.sv
// tb_ffo_pos_decoder: directed stimulus with a reference frame model; expected
// words are queued when a frame's last beat is accepted and compared when the
// DUT hands the word off.
module tb_ffo_pos_decoder;

    localparam int unsigned W  = 32;
    localparam int unsigned PW = 5;

    typedef struct packed {
        logic [0:W-1] b;
        logic [0:PW]  cnt;
        logic         dup;
        logic         err;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic          in_v;
    logic [0:PW-1] in_p;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [0:W-1]  out_b;
    logic [0:PW]   out_cnt;
    logic          out_dup;
    logic          out_err;

    int   passes = 0;
    int   total  = 0;
    exp_t sb[$];

    // Reference frame state.
    logic [0:W-1] m_b;
    logic         m_dup;
    logic         m_err;

    ffo_pos_decoder #(.W(W), .PW(PW)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_v     (in_v),
        .in_p     (in_p),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_b    (out_b),
        .out_cnt  (out_cnt),
        .out_dup  (out_dup),
        .out_err  (out_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    task automatic model_clear();
        m_b   = '0;
        m_dup = 1'b0;
        m_err = 1'b0;
    endtask

    task automatic push_exp(input logic [0:W-1] b, input logic dup, input logic err);
        exp_t e;
        e.b   = b;
        e.cnt = (PW + 1)'($countones(b));
        e.dup = dup;
        e.err = err;
        sb.push_back(e);
    endtask

    // Apply one accepted beat to the reference model.
    task automatic model_beat(input logic v, input int p, input logic last);
        logic [0:W-1] bit_vec;
        if (v) begin
            if (p < int'(W)) begin
                bit_vec = '0;
                bit_vec[p] = 1'b1;
                if ((m_b & bit_vec) != '0) m_dup = 1'b1;
                else m_b = m_b | bit_vec;
            end else begin
                m_err = 1'b1;
            end
        end
        if (last) begin
            push_exp(m_b, m_dup, m_err);
            model_clear();
        end
    endtask

    // Drive one beat and wait (bounded) for it to be accepted.
    task automatic beat(input logic v, input int p, input logic last);
        logic took;
        int   tries;
        in_valid = 1'b1;
        in_v     = v;
        in_p     = PW'(p);
        in_last  = last;
        took     = 1'b0;
        tries    = 0;
        while (!took && tries < 50) begin
            @(negedge clk);
            took = in_ready;
            @(posedge clk);
            #1;
            tries++;
        end
        in_valid = 1'b0;
        if (took) model_beat(v, p, last);
        else chk("accept_timeout", 64'(took), 64'd1);
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        reset = 1'b0;
        model_clear();
    endtask

    // Scoreboard: compare each handed-off word against the oldest expectation.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_word", 64'(out_b), 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_out_b",   64'(out_b),   64'(e.b));
                chk("sb_out_cnt", 64'(out_cnt), 64'(e.cnt));
                chk("sb_out_dup", 64'(out_dup), 64'(e.dup));
                chk("sb_out_err", 64'(out_err), 64'(e.err));
            end
        end
    end

    initial begin
        logic [0:W-1] held;
        int           waited;
        in_valid  = 1'b0;
        in_v      = 1'b0;
        in_p      = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        model_clear();

        // Reset state.
        do_reset(2);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_b",     64'(out_b),     64'd0);
        chk("rst_out_cnt",   64'(out_cnt),   64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);

        // First beat after reset: single-beat frame at position 3.
        beat(1'b1, 3, 1'b1);
        chk("p3_out_valid", 64'(out_valid), 64'd1);
        chk("p3_out_b",     64'(out_b),     64'h10000000);
        chk("p3_out_cnt",   64'(out_cnt),   64'd1);
        chk("p3_out_dup",   64'(out_dup),   64'd0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("p3_drained", 64'(out_valid), 64'd0);

        // Multi-beat frame; out_valid pulses for one cycle.
        beat(1'b1, 0, 1'b0);
        beat(1'b1, 31, 1'b0);
        beat(1'b1, 7, 1'b1);
        chk("multi_out_b",   64'(out_b),     64'h81000001);
        chk("multi_out_cnt", 64'(out_cnt),   64'd3);
        chk("multi_valid",   64'(out_valid), 64'd1);
        @(posedge clk); #1;
        chk("multi_one_cycle", 64'(out_valid), 64'd0);

        // Duplicate and null beats.
        beat(1'b1, 5, 1'b0);
        beat(1'b0, 9, 1'b0);
        beat(1'b1, 5, 1'b1);
        chk("dup_out_b",   64'(out_b),   64'h04000000);
        chk("dup_out_cnt", 64'(out_cnt), 64'd1);
        chk("dup_out_dup", 64'(out_dup), 64'd1);
        chk("dup_out_err", 64'(out_err), 64'd0);
        @(posedge clk); #1;

        // Backpressure: word held while out_ready is low.
        out_ready = 1'b0;
        beat(1'b1, 10, 1'b1);
        held     = out_b;
        chk("bp_word", 64'(held), 64'h00200000);
        in_valid = 1'b1;
        in_v     = 1'b1;
        in_p     = PW'(2);
        in_last  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_stable",   64'(out_b),    64'(held));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        model_beat(1'b1, 2, 1'b1);
        in_valid = 1'b0;
        chk("bp_next_valid", 64'(out_valid), 64'd1);
        chk("bp_next_b",     64'(out_b),     64'h20000000);
        @(posedge clk); #1;

        // Back-to-back single-beat frames.
        beat(1'b1, 12, 1'b1);
        beat(1'b1, 20, 1'b1);
        beat(1'b1, 29, 1'b1);
        chk("b2b_valid", 64'(out_valid), 64'd1);
        @(posedge clk); #1;

        // Full set, then an all-null frame.
        for (int p = 0; p < int'(W); p++) beat(1'b1, p, p == int'(W) - 1);
        chk("full_out_b",   64'(out_b),   64'hFFFFFFFF);
        chk("full_out_cnt", 64'(out_cnt), 64'd32);
        chk("full_out_dup", 64'(out_dup), 64'd0);
        for (int i = 0; i < 3; i++) beat(1'b0, i + 4, i == 2);
        chk("null_out_b",   64'(out_b),   64'd0);
        chk("null_out_cnt", 64'(out_cnt), 64'd0);
        @(posedge clk); #1;

        // Reset mid-frame discards the partial frame.
        beat(1'b1, 4, 1'b0);
        beat(1'b1, 6, 1'b0);
        do_reset(1);
        beat(1'b1, 1, 1'b1);
        chk("midrst_out_b",   64'(out_b),   64'h40000000);
        chk("midrst_out_cnt", 64'(out_cnt), 64'd1);
        @(posedge clk); #1;

        // Reset while holding a word drops it.
        out_ready = 1'b0;
        beat(1'b1, 9, 1'b1);
        chk("hold_valid", 64'(out_valid), 64'd1);
        void'(sb.pop_back());
        do_reset(1);
        chk("hold_rst_valid", 64'(out_valid), 64'd0);
        chk("hold_rst_ready", 64'(in_ready),  64'd1);

        // Drain any outstanding expectations.
        out_ready = 1'b1;
        waited    = 0;
        while (sb.size() != 0 && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
